// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and readiness rule for the forwarding scoreboard
package fwd_pkg;

  localparam int REG_W = 5;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } entry_t;

  // A producer's result can be forwarded once it sits at or beyond its ready index.
  function automatic logic ready(input logic is_load, input int k,
                                 input int load_ready, input int alu_ready);
    return is_load ? (k >= load_ready) : (k >= alu_ready);
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// rtl/fwd_port_sel.sv - per-port youngest-match forwarding select
module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int ALU_READY  = 0
) (
  input  logic [REG_W-1:0]       rs,
  input  logic [XLEN-1:0]        rf,
  input  logic [DEPTH-1:0]       ent_valid,
  input  logic [REG_W*DEPTH-1:0] ent_rd,
  input  logic [DEPTH-1:0]       ent_is_load,
  input  logic [XLEN*DEPTH-1:0]  stage_data,
  output logic [XLEN-1:0]        data,
  output logic                   fwd,
  output logic                   hazard
);

  // Walk oldest to youngest so the youngest match decides, ready or not.
  always_comb begin
    data   = rf;
    fwd    = 1'b0;
    hazard = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent_valid[k] && (ent_rd[k*REG_W +: REG_W] == rs) && (rs != '0)) begin
        if (ready(ent_is_load[k], k, LOAD_READY, ALU_READY)) begin
          data   = stage_data[k*XLEN +: XLEN];
          fwd    = 1'b1;
          hazard = 1'b0;
        end else begin
          data   = rf;
          fwd    = 1'b0;
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - in-flight producer scoreboard, operand forwarding and load-use stall
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 3,
  parameter int NUM_PORTS  = 2,
  parameter int LOAD_READY = 2,
  parameter int ALU_READY  = 0,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hold,
  input  logic                       flush,
  input  logic                       iss_valid,
  input  logic [REG_W-1:0]           iss_rd,
  input  logic                       iss_is_load,
  input  logic [REG_W*NUM_PORTS-1:0] rs_addr,
  input  logic [XLEN*NUM_PORTS-1:0]  rf_data,
  input  logic [XLEN*DEPTH-1:0]      stage_data,
  output logic [XLEN*NUM_PORTS-1:0]  op_data,
  output logic [NUM_PORTS-1:0]       op_fwd,
  output logic                       stall,
  output logic [CNT_W-1:0]           stall_count
);

  entry_t                 sb [DEPTH];
  logic [DEPTH-1:0]       ent_valid;
  logic [DEPTH-1:0]       ent_is_load;
  logic [REG_W*DEPTH-1:0] ent_rd;
  logic [NUM_PORTS-1:0]   port_hazard;
  logic                   bubble;

  always_comb begin
    ent_valid   = '0;
    ent_is_load = '0;
    ent_rd      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ent_valid[k]               = sb[k].valid;
      ent_is_load[k]             = sb[k].is_load;
      ent_rd[k*REG_W +: REG_W]   = sb[k].rd;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    fwd_port_sel #(
      .XLEN      (XLEN),
      .DEPTH     (DEPTH),
      .LOAD_READY(LOAD_READY),
      .ALU_READY (ALU_READY)
    ) u_sel (
      .rs         (rs_addr[p*REG_W +: REG_W]),
      .rf         (rf_data[p*XLEN +: XLEN]),
      .ent_valid  (ent_valid),
      .ent_rd     (ent_rd),
      .ent_is_load(ent_is_load),
      .stage_data (stage_data),
      .data       (op_data[p*XLEN +: XLEN]),
      .fwd        (op_fwd[p]),
      .hazard     (port_hazard[p])
    );
  end

  assign stall  = rst_n & (|port_hazard);
  // x0 writes are never tracked, and a stalled or flushed decode slot becomes a bubble.
  assign bubble = stall | flush | ~iss_valid | (iss_rd == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
      stall_count <= '0;
    end else begin
      if (!hold) begin
        sb[0] <= '{valid: ~bubble, rd: iss_rd, is_load: iss_is_load};
        for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
      end
      if (stall && (stall_count != {CNT_W{1'b1}})) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - randomized and directed checks of fwd_scoreboard against a queue model
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n, hold, flush, iss_valid, iss_is_load;
  logic [4:0]  iss_rd;
  logic [9:0]  rs_addr;
  logic [63:0] rf_data;
  logic [95:0] stage_data;
  logic [63:0] op_data, op_data4;
  logic [1:0]  op_fwd, op_fwd4;
  logic        stall, stall4;
  logic [31:0] stall_count;
  logic [3:0]  stall_count4;

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .iss_is_load(iss_is_load), .rs_addr(rs_addr), .rf_data(rf_data),
    .stage_data(stage_data), .op_data(op_data), .op_fwd(op_fwd), .stall(stall),
    .stall_count(stall_count)
  );

  fwd_scoreboard #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .iss_is_load(iss_is_load), .rs_addr(rs_addr), .rf_data(rf_data),
    .stage_data(stage_data), .op_data(op_data4), .op_fwd(op_fwd4), .stall(stall4),
    .stall_count(stall_count4)
  );

  int total = 0;
  int bad   = 0;

  // Model: list of in-flight producers, index 0 youngest.
  bit          m_valid [3];
  logic [4:0]  m_rd    [3];
  bit          m_load  [3];
  int unsigned m_cnt;
  logic [31:0] e_data  [2];
  bit          e_fwd   [2];
  bit          e_haz   [2];
  bit          e_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_eval();
    for (int p = 0; p < 2; p++) begin
      logic [4:0] rs;
      bit done;
      rs = rs_addr[p*5 +: 5];
      done = 0;
      e_data[p] = rf_data[p*32 +: 32];
      e_fwd[p] = 0;
      e_haz[p] = 0;
      for (int k = 0; k < 3; k++) begin
        if (!done && m_valid[k] && m_rd[k] == rs && rs != 0) begin
          done = 1;
          if (m_load[k] ? (k >= 2) : 1'b1) begin
            e_fwd[p] = 1;
            e_data[p] = stage_data[k*32 +: 32];
          end else begin
            e_haz[p] = 1;
          end
        end
      end
    end
    e_stall = rst_n && (e_haz[0] || e_haz[1]);
  endtask

  task automatic settle();
    #1;
    model_eval();
    for (int p = 0; p < 2; p++) begin
      if (!e_haz[p]) check("op_data", op_data[p*32 +: 32], e_data[p]);
      check("op_fwd", op_fwd[p], e_fwd[p]);
    end
    check("stall", stall, e_stall);
    check("stall4", stall4, e_stall);
    check("stall_count", stall_count, m_cnt);
    check("stall_count4", stall_count4, (m_cnt > 15) ? 15 : m_cnt);
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) m_valid[k] = 0;
      m_cnt = 0;
    end else begin
      if (e_stall && m_cnt != 32'hffff_ffff) m_cnt++;
      if (!hold) begin
        for (int k = 2; k > 0; k--) begin
          m_valid[k] = m_valid[k-1];
          m_rd[k]    = m_rd[k-1];
          m_load[k]  = m_load[k-1];
        end
        m_valid[0] = iss_valid && !flush && !e_stall && iss_rd != 0;
        m_rd[0]    = iss_rd;
        m_load[0]  = iss_is_load;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    iss_valid = 0; rs_addr = '0; hold = 0; flush = 0;
    repeat (3) begin settle(); tick(); end
  endtask

  task automatic issue(input logic [4:0] rd, input logic ld);
    iss_valid = 1; iss_rd = rd; iss_is_load = ld;
    settle(); tick();
    iss_valid = 0;
  endtask

  initial begin
    rst_n = 0; hold = 0; flush = 0; iss_valid = 0; iss_rd = '0; iss_is_load = 0;
    rs_addr = '0; rf_data = 64'h0000_beef_0000_cafe;
    stage_data = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    for (int k = 0; k < 3; k++) begin m_valid[k] = 0; m_rd[k] = '0; m_load[k] = 0; end
    m_cnt = 0;
    @(negedge clk);
    settle();
    check("reset_stall", stall, 0);
    tick(); tick();
    rst_n = 1;
    settle();
    check("post_reset_fwd", op_fwd, 0);
    check("post_reset_data0", op_data[31:0], 32'h0000_cafe);
    check("post_reset_data1", op_data[63:32], 32'h0000_beef);

    // ALU back-to-back
    issue(5'd5, 0);
    rs_addr = {5'd0, 5'd5};
    stage_data[31:0] = 32'h1234;
    settle();
    check("alu_data", op_data[31:0], 32'h1234);
    check("alu_fwd", op_fwd, 2'b01);
    check("alu_stall", stall, 0);
    tick();
    stage_data = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    drain();

    // Load-use
    issue(5'd7, 1);
    rs_addr = {5'd7, 5'd0};
    settle(); check("lu_stall_c1", stall, 1); tick();
    settle(); check("lu_stall_c2", stall, 1); tick();
    settle();
    check("lu_stall_c3", stall, 0);
    check("lu_data", op_data[63:32], 32'hCCCC0002);
    check("lu_count", stall_count, 2);
    tick();
    drain();

    // Youngest wins
    issue(5'd3, 0);
    issue(5'd3, 1);
    rs_addr = {5'd0, 5'd3};
    settle(); check("yw_stall", stall, 1); check("yw_fwd", op_fwd, 0); tick();
    settle(); check("yw_stall2", stall, 1); check("yw_fwd2", op_fwd, 0); tick();
    settle(); check("yw_data", op_data[31:0], 32'hCCCC0002); check("yw_stall3", stall, 0); tick();
    drain();

    // x0 and no-match
    issue(5'd0, 0);
    issue(5'd4, 0);
    rs_addr = {5'd0, 5'd9};
    settle();
    check("x0_fwd", op_fwd, 0);
    check("x0_data", op_data[31:0], 32'h0000_cafe);
    tick();
    drain();

    // Hold, then flush
    issue(5'd7, 1);
    rs_addr = {5'd7, 5'd0};
    hold = 1;
    repeat (3) begin settle(); check("hold_stall", stall, 1); tick(); end
    hold = 0;
    settle(); check("unhold_stall1", stall, 1); tick();
    settle(); check("unhold_stall2", stall, 1); tick();
    settle(); check("unhold_stall3", stall, 0); tick();
    drain();
    flush = 1; iss_valid = 1; iss_rd = 5'd8; iss_is_load = 0;
    settle(); tick();
    flush = 0; iss_valid = 0;
    rs_addr = {5'd0, 5'd8};
    repeat (3) begin settle(); check("flush_fwd", op_fwd[0], 0); tick(); end
    drain();

    // Reset mid-stall
    issue(5'd7, 1);
    rs_addr = {5'd7, 5'd0};
    settle(); check("rms_stall", stall, 1);
    rst_n = 0;
    settle(); check("rms_stall_rst", stall, 0);
    tick();
    rst_n = 1;
    settle(); check("rms_count", stall_count, 0); check("rms_stall_after", stall, 0);
    tick();

    // Saturation of the narrow counter
    rs_addr = '0;
    issue(5'd7, 1);
    rs_addr = {5'd7, 5'd0};
    hold = 1;
    repeat (20) begin settle(); tick(); end
    settle();
    check("sat_count32", stall_count, 20);
    check("sat_count4", stall_count4, 15);
    hold = 0;
    tick();

    // Randomized
    for (int i = 0; i < 1500; i++) begin
      rst_n       = ($urandom_range(0, 63) != 0);
      hold        = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      iss_valid   = ($urandom_range(0, 3) != 0);
      iss_rd      = 5'($urandom_range(0, 7));
      iss_is_load = ($urandom_range(0, 2) == 0);
      rs_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rf_data     = {$urandom, $urandom};
      stage_data  = {$urandom, $urandom, $urandom};
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised operand-forwarding and hazard unit for the RISC-V core; successor to the fixed two-operand branch forwarding select.
- Tracks the destination registers of the last DEPTH in-flight producers in a shift-register scoreboard.
- For each of NUM_PORTS source-operand read ports, selects the youngest ready producer or the regfile value. Raises a load-use stall when the youngest match is not yet ready.
- Sits between decode (regfile read) and the EX-stage operand/branch comparators.

Parameters:
- XLEN, 32, datapath width
- DEPTH, 3, in-flight producer entries tracked (entry 0 = EX, 1 = MEM, 2 = WB)
- NUM_PORTS, 2, source-operand ports served (rs1, rs2, ...)
- LOAD_READY, 2, lowest entry index at which load data is valid
- ALU_READY, 0, lowest entry index at which non-load result data is valid
- CNT_W, 32, width of stall performance counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- hold  in  1  global pipeline freeze; scoreboard does not shift
- flush  in  1  kill the instruction leaving decode; insert bubble
- iss_valid  in  1  decode instruction issues a register write
- iss_rd  in  5  destination register of issuing instruction
- iss_is_load  in  1  issuing instruction is a load
- rs_addr  in  5*NUM_PORTS  source register per port, port p at [5p+4:5p]
- rf_data  in  XLEN*NUM_PORTS  regfile read data per port
- stage_data  in  XLEN*DEPTH  result currently held in pipeline stage of entry k
- op_data  out  XLEN*NUM_PORTS  forwarded operand per port
- op_fwd  out  NUM_PORTS  port p is using a forwarded value
- stall  out  1  load-use hazard; decode must hold
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Entry state, per k: valid, rd[4:0], is_load. Reset: all valid=0, stall_count=0. Other fields don't-care.
- Advance = !hold. On advance: entry[k] <= entry[k-1] for k>=1, and entry[0] <= issuing instruction. Entry 0 is a bubble (valid=0) if stall, flush, !iss_valid, or iss_rd==0.
- When hold=1, all entries keep their values, including valid.
- Match for port p at entry k: valid && rd==rs_addr[p] && rs_addr[p]!=0.
- Ready for entry k: is_load ? (k>=LOAD_READY) : (k>=ALU_READY).
- Selection is combinational, same cycle. The youngest match (lowest k) wins.
  - Youngest match ready: op_data[p]=stage_data[k], op_fwd[p]=1.
  - No match, or rs_addr[p]==0: op_data[p]=rf_data[p], op_fwd[p]=0.
  - Youngest match not ready: port hazard; op_data[p]=rf_data[p] (don't-care), op_fwd[p]=0.
  - An older ready match must never override a younger unready one.
- stall = OR of port hazards, gated with rst_n; forced 0 when rst_n=0.
- Values after reset deassert: stall=0, op_fwd=0, op_data=rf_data.
- Stall, simultaneous events and flush:
  - Stall with advance: the bubble enters entry 0 and the producer moves to k+1. Stall persists until the producer reaches a ready index (one cycle for LOAD_READY=1 past the EX position).
  - Stall with hold: the state is frozen, so stall persists.
  - flush and iss_valid together: flush wins (bubble).
  - stall and flush together: bubble.
- stall_count increments by 1 on each cycle with stall=1 && rst_n=1. It saturates at all-ones and never wraps.
- Reset mid-stall: next cycle all entries invalid, stall=0, count 0.
- Writes to x0 are never tracked; x0 reads always return rf_data (regfile returns 0).

Decomposition:
- Shared package fwd_pkg:
  - REG_W=5
  - entry struct {valid, rd, is_load}
  - function ready(is_load, k)
- One sub-module, fwd_port_sel: a per-port priority search over the DEPTH entries producing {data, fwd, hazard}. Instantiated NUM_PORTS times in a generate loop.
- The top holds the scoreboard registers, stall OR-reduction and counter.

Test Plan:
- ALU back-to-back: issue add x5 (not load), next cycle rs_addr[0]=5, stage_data[0]=0x1234 -> op_data[0]=0x1234, op_fwd=01, stall=0.
- Load-use: issue lw x7; next cycle rs_addr[1]=7 -> stall=1 for 2 cycles (entries 0,1 not ready). Third cycle op_data[1]=stage_data[2], stall=0, stall_count=2.
- Youngest wins: addi x3 then lw x3; read x3 one cycle after lw -> stall=1 (lw at entry 0). Forward must not take the older addi at entry 1.
- x0 and no-match: rs_addr={0,9}, entries hold rd=0 bubble and rd=4 -> op_fwd=00, op_data=rf_data.
- Hold and flush: lw x7 in entry 0 with hold=1 for 3 cycles -> stall stays 1, entries frozen. Flush with iss_valid=1, iss_rd=8 -> a later read of x8 is not forwarded.
- Reset mid-stall: rst_n=0 during load-use stall -> stall=0 immediately, stall_count=0 after the edge. Counter preloaded near saturation with CNT_W=4 -> stays at 15.
